// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver slice: frame-controller state encoding
// and the legal oversample ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_e;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  function automatic logic is_legal_prescale(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit-position counter for the UART receiver.
// Edge count wraps at last_edge and carries into the bit count; clr wins over en.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] last_edge,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               edge_wrap
);

  assign edge_wrap = (edge_cnt == last_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (edge_wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: start detection, bit/edge tracking, one-cycle
// strobes to the sampler/deserializer/checkers, and data_valid qualification.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e          state, state_nxt;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic [PRESC_W-1:0] last_edge;
  logic               cnt_en, cnt_clr;
  logic               edge_wrap;
  logic               start_frame;

  // A new frame may also begin straight out of CHECK, so the frame settings are
  // captured on every entry to START; an illegal ratio falls back to 8 so the
  // edge counter can never run without a reachable wrap point.
  assign start_frame = ((state == IDLE) || (state == CHECK)) && !RX_IN;
  assign last_edge   = presc_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= PRESC_W'(PRESC_8);
      par_en_q <= 1'b0;
    end else if (start_frame) begin
      presc_q  <= is_legal_prescale(32'(prescale)) ? prescale : PRESC_W'(PRESC_8);
      par_en_q <= PAR_EN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .last_edge (last_edge),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .edge_wrap (edge_wrap)
  );

  always_comb begin
    state_nxt   = state;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;

    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!RX_IN) state_nxt = START;
      end

      START: begin
        dat_samp_en = 1'b1;
        cnt_en      = 1'b1;
        if (edge_wrap) begin
          strt_chk_en = 1'b1;
          state_nxt   = DATA;
        end
      end

      DATA: begin
        dat_samp_en = 1'b1;
        // The start checker's verdict lands on the first DATA cycle; a high
        // start sample means the falling edge was only noise.
        if ((bit_cnt == 4'd1) && (edge_cnt == '0) && strt_glitch) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (edge_wrap) begin
            deser_en = 1'b1;
            if (bit_cnt == LAST_DATA_BIT) state_nxt = par_en_q ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        dat_samp_en = 1'b1;
        cnt_en      = 1'b1;
        if (edge_wrap) begin
          par_chk_en = 1'b1;
          state_nxt  = STOP;
        end
      end

      STOP: begin
        dat_samp_en = 1'b1;
        cnt_en      = 1'b1;
        if (edge_wrap) begin
          stp_chk_en = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = CHECK;
        end
      end

      CHECK: begin
        cnt_clr    = 1'b1;
        data_valid = !stp_err && !(par_en_q && par_err);
        state_nxt  = RX_IN ? IDLE : START;
      end

      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({deser_en, strt_chk_en, par_chk_en, stp_chk_en}));

  a_valid_in_check: assert property (@(posedge clk) disable iff (!rst_n)
    data_valid |-> (state == CHECK));

endmodule
